vector_memory_access_unit: RTL and testbench
============================================

Name: vector_memory_access_unit

Overview:
- Memory-stage block directly downstream of the conditional unit.
- Consumes the condition-qualified MemWriteM/MemReadM plus the EX/MEM address and data.
- Performs scalar (1-beat) or 128-bit vector (4-beat) accesses to a 32-bit data memory over a req/ack handshake.
- Stalls the pipeline until the access completes, then presents the read data to the M/W register.

Parameters:
- BEATS, 4, 32-bit beats per vector access (vector width = 32*BEATS).
- TIMEOUT, 64, cycles without mem_ack before fault (only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- MemWriteM  input  1  write request (condition-qualified).
- MemReadM  input  1  read request.
- VecM  input  1  1 = vector access, 0 = scalar.
- ALUResultM  input  32  byte address.
- WriteDataM  input  32  scalar write data.
- WriteVecDataM  input  128  vector write data.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write beat.
- mem_addr  output  32  word-aligned beat address.
- mem_wdata  output  32  beat write data.
- mem_rdata  input  32  beat read data, valid with mem_ack.
- mem_ack  input  1  beat accepted/completed.
- ReadDataM  output  32  scalar read result.
- ReadVecDataM  output  128  vector read result.
- StallM  output  1  freeze IF..EX/MEM registers.
- DoneM  output  1  one-cycle access-complete pulse.

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, all outputs 0, data buffers 0. Reset during an access aborts it; mem_req drops immediately; no partial result is retained.
- States: IDLE, REQ, DONE.
- Op present = MemWriteM | MemReadM. If both are set, treat as write and ignore the read.
- IDLE:
  - With an op present, capture address (bits [1:0] forced to 00), write data, direction, and VecM.
  - Set the beat count to 0 for scalar or BEATS-1 for vector, then go to REQ.
  - StallM = op present, combinational, in this cycle.
- REQ:
  - mem_req=1, mem_we=captured direction.
  - mem_addr = base + 4*beat.
  - mem_wdata = beat lane: vector lane k = bits [32k+31:32k]; scalar uses WriteDataM.
  - Outputs are held stable until mem_ack is sampled 1.
  - On ack, a read writes mem_rdata into lane k, or into ReadDataM for scalar.
  - If beat = last, go to DONE; otherwise beat+1 with mem_req kept high (back-to-back beats allowed).
  - StallM=1 throughout.
- DONE:
  - DoneM=1, StallM=0, mem_req=0. The pipeline advances this cycle.
  - Unconditional return to IDLE.
  - The op still visible on the inputs during DONE is ignored.
- Latency: scalar with immediate ack = 3 cycles (IDLE→REQ→DONE). Vector = 2 + total ack cycles.
- A write has no read data: ReadDataM/ReadVecDataM hold their previous values.
- Address arithmetic is 32-bit with wrap-around: base 0xFFFFFFF8 vector beats go to FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counts REQ cycles without ack; it clears on each ack.
  - When it reaches TIMEOUT, go to DONE, assert an extra output FaultM=1 for that cycle, and leave read buffers unchanged.
  - FaultM resets to 0.
- Undefined: no watchdog, no FaultM port; REQ waits indefinitely.

Decomposition:
- Shared package (mem_pkg):
  - mem_state_t enum {IDLE, REQ, DONE}.
  - WORD_W=32, VEC_W=128, BEAT_STRIDE=4.
- One natural sub-module: beat_lane_mux, which selects/inserts a 32-bit lane of the 128-bit vector by beat index. It is instantiated for both write-lane selection and read-lane insertion.
- Result buffers use the existing parameterised register with enable.

Test Plan:
- Scalar read: MemReadM=1, VecM=0, addr 0x00000103, ack on first REQ cycle, rdata 0xDEADBEEF → mem_addr 0x00000100, ReadDataM=0xDEADBEEF, DoneM on cycle 3, StallM high cycles 1-2.
- Vector write: addr 0x40, data 0x33333333_22222222_11111111_00000000, ack every cycle → addrs 0x40/44/48/4C with wdata 0x0/0x11111111/0x22222222/0x33333333, DoneM at cycle 6.
- Vector read with ack delayed 2 cycles per beat → mem_req/mem_addr stable during waits, ReadVecDataM assembled lane-ordered, StallM high for 1+12 cycles.
- Both MemWriteM and MemReadM set → mem_we=1, ReadDataM unchanged.
- Reset asserted during beat 2 of a vector read → mem_req=0 and StallM=0 immediately, ReadVecDataM=0, next op starts at beat 0.
- MEM_TIMEOUT_EN, TIMEOUT=64, no ack → FaultM and DoneM pulse on the 65th REQ cycle, then IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the vector memory access unit.
package mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned VEC_W       = 128;
  localparam int unsigned BEAT_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

endpackage

// File: rtl/beat_lane_mux.sv
// Selects the 32-bit lane of a vector addressed by a beat index, and returns a copy of the
// vector with that lane replaced by lane_i.
module beat_lane_mux import mem_pkg::*; #(
  parameter int unsigned Beats = 4,
  parameter int unsigned IdxW  = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic [WORD_W*Beats-1:0] vec_i,
  input  logic [IdxW-1:0]         idx_i,
  input  logic [WORD_W-1:0]       lane_i,
  output logic [WORD_W-1:0]       lane_o,
  output logic [WORD_W*Beats-1:0] vec_o
);

  // Lane extract and lane insert share one index decode.
  always_comb begin
    lane_o = '0;
    vec_o  = vec_i;
    for (int unsigned k = 0; k < Beats; k++) begin
      if (idx_i == IdxW'(k)) begin
        lane_o                     = vec_i[k*WORD_W +: WORD_W];
        vec_o[k*WORD_W +: WORD_W]  = lane_i;
      end
    end
  end

endmodule

// File: rtl/en_reg.sv
// Parameterised register with load enable and asynchronous active-low reset to zero.
module en_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  // Load on enable, otherwise hold.
  always_comb begin
    q_d = en_i ? d_i : q_q;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vector_memory_access_unit.sv
// Memory-stage access unit: scalar (1 beat) or vector (BEATS beats) accesses over a
// req/ack handshake, stalling the pipeline until the access completes.
// Optional watchdog and FaultM output enabled by defining MEM_TIMEOUT_EN.
module vector_memory_access_unit import mem_pkg::*; #(
  parameter int unsigned BEATS   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MemWriteM,
  input  logic                    MemReadM,
  input  logic                    VecM,
  input  logic [31:0]             ALUResultM,
  input  logic [31:0]             WriteDataM,
  input  logic [WORD_W*BEATS-1:0] WriteVecDataM,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             ReadDataM,
  output logic [WORD_W*BEATS-1:0] ReadVecDataM,
  output logic                    StallM,
  output logic                    DoneM
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                    FaultM
`endif
);

  localparam int unsigned IdxW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned VecW = WORD_W * BEATS;

  mem_state_t      state_q, state_d;
  logic [IdxW-1:0] beat_q, beat_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [31:0]     base_q, base_d;
  logic            we_q, we_d;
  logic            vec_q, vec_d;
  logic [VecW-1:0] wvec_q, wvec_d;

  logic            op;
  logic            rd_fire;
  logic [31:0]     wr_lane;
  logic [VecW-1:0] rd_vec_ins;
  logic [VecW-1:0] unused_wr_vec;
  logic [31:0]     unused_rd_lane;
  logic [1:0]      unused_addr_lsb;

  assign op              = MemWriteM | MemReadM;
  assign unused_addr_lsb = ALUResultM[1:0];

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       fault_q, fault_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  // Next-state: capture the op in IDLE, step beats on ack in REQ, always leave DONE.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    base_d  = base_q;
    we_d    = we_q;
    vec_d   = vec_q;
    wvec_d  = wvec_q;
`ifdef MEM_TIMEOUT_EN
    wdog_d  = wdog_q;
    fault_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (op) begin
          state_d = REQ;
          base_d  = {ALUResultM[31:2], 2'b00};
          // Write wins when both directions are requested.
          we_d    = MemWriteM;
          vec_d   = VecM;
          wvec_d  = VecM ? WriteVecDataM : VecW'(WriteDataM);
          beat_d  = '0;
          last_d  = VecM ? IdxW'(BEATS - 1) : '0;
`ifdef MEM_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (beat_q == last_q) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_q == 8'(TIMEOUT - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and captured-request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      vec_q   <= 1'b0;
      wvec_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      wdog_q  <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      base_q  <= base_d;
      we_q    <= we_d;
      vec_q   <= vec_d;
      wvec_q  <= wvec_d;
`ifdef MEM_TIMEOUT_EN
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
`endif
    end
  end

  beat_lane_mux #(
    .Beats (BEATS),
    .IdxW  (IdxW)
  ) u_wr_lane (
    .vec_i  (wvec_q),
    .idx_i  (beat_q),
    .lane_i ('0),
    .lane_o (wr_lane),
    .vec_o  (unused_wr_vec)
  );

  beat_lane_mux #(
    .Beats (BEATS),
    .IdxW  (IdxW)
  ) u_rd_lane (
    .vec_i  (ReadVecDataM),
    .idx_i  (beat_q),
    .lane_i (mem_rdata),
    .lane_o (unused_rd_lane),
    .vec_o  (rd_vec_ins)
  );

  assign rd_fire = (state_q == REQ) & mem_ack & ~we_q;

  en_reg #(
    .Width (32)
  ) u_rd_scalar (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rd_fire & ~vec_q),
    .d_i    (mem_rdata),
    .q_o    (ReadDataM)
  );

  en_reg #(
    .Width (VecW)
  ) u_rd_vec (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rd_fire & vec_q),
    .d_i    (rd_vec_ins),
    .q_o    (ReadVecDataM)
  );

  // Handshake outputs decode from state; StallM is forced low while reset is held.
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? base_q + 32'(BEAT_STRIDE) * 32'(beat_q) : '0;
    mem_wdata = mem_we ? wr_lane : '0;
    DoneM     = (state_q == DONE);
    StallM    = rst & (((state_q == IDLE) & op) | mem_req);
  end

`ifdef MEM_TIMEOUT_EN
  assign FaultM = fault_q;
`endif

endmodule

// File: tb/tb_vector_memory_access_unit.sv
// Directed self-checking bench for vector_memory_access_unit (default build).
module tb_vector_memory_access_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         MemWriteM = 1'b0;
  logic         MemReadM = 1'b0;
  logic         VecM = 1'b0;
  logic [31:0]  ALUResultM = '0;
  logic [31:0]  WriteDataM = '0;
  logic [127:0] WriteVecDataM = '0;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [31:0]  ReadDataM;
  logic [127:0] ReadVecDataM;
  logic         StallM;
  logic         DoneM;
`ifdef MEM_TIMEOUT_EN
  logic         FaultM;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int stalls;

  always #5 clk = ~clk;

  vector_memory_access_unit #(
    .BEATS   (4),
    .TIMEOUT (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .MemWriteM     (MemWriteM),
    .MemReadM      (MemReadM),
    .VecM          (VecM),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .WriteVecDataM (WriteVecDataM),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .ReadDataM     (ReadDataM),
    .ReadVecDataM  (ReadVecDataM),
    .StallM        (StallM),
    .DoneM         (DoneM)
`ifdef MEM_TIMEOUT_EN
    ,
    .FaultM        (FaultM)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One vector access; ack arrives after `delay` wait cycles in each beat.
  // exp_addrs / exp_wd pack the per-beat expectations, beat 0 in the low word.
  task automatic vec_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [127:0] wv, input int delay, input logic [31:0] rbase,
                            input logic [127:0] exp_addrs, input logic [127:0] exp_wd);
    logic [127:0] ea;
    logic [127:0] ew;
    ea = exp_addrs;
    ew = exp_wd;
    @(posedge clk); #1;
    MemWriteM = we; MemReadM = ~we; VecM = 1'b1; ALUResultM = addr; WriteVecDataM = wv;
    @(negedge clk);
    stalls = StallM ? 1 : 0;
    check($sformatf("%s_idle_req", tag), mem_req, 1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w <= delay; w++) begin
        @(posedge clk); #1;
        mem_ack   = (w == delay);
        mem_rdata = (w == delay) ? rbase + 32'(b) : 32'hFFFF0000;
        @(negedge clk);
        if (StallM) stalls++;
        check($sformatf("%s_req_b%0d_w%0d", tag, b, w), mem_req, 1'b1);
        check($sformatf("%s_addr_b%0d_w%0d", tag, b, w), mem_addr, ea[32*b +: 32]);
        check($sformatf("%s_we_b%0d", tag, b), mem_we, we);
        if (we) check($sformatf("%s_wdata_b%0d", tag, b), mem_wdata, ew[32*b +: 32]);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; MemWriteM = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    check($sformatf("%s_done", tag), DoneM, 1'b1);
    check($sformatf("%s_done_stall", tag), StallM, 1'b0);
    check($sformatf("%s_done_req", tag), mem_req, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_stall", StallM, 1'b0);
    check("rst_done", DoneM, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_rvec", ReadVecDataM, 128'h0);
    #2 rst = 1'b1;

    // Scalar read, misaligned address, immediate ack
    @(posedge clk); #1;
    MemReadM = 1'b1; VecM = 1'b0; ALUResultM = 32'h00000103;
    @(negedge clk);
    check("s1_c1_stall", StallM, 1'b1);
    check("s1_c1_req", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("s1_c2_req", mem_req, 1'b1);
    check("s1_c2_addr", mem_addr, 32'h00000100);
    check("s1_c2_we", mem_we, 1'b0);
    check("s1_c2_stall", StallM, 1'b1);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("s1_c3_done", DoneM, 1'b1);
    check("s1_c3_stall", StallM, 1'b0);
    check("s1_c3_rdata", ReadDataM, 32'hDEADBEEF);
    // Op still held during DONE must not restart an access.
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    check("s1_c4_req", mem_req, 1'b0);
    check("s1_c4_done", DoneM, 1'b0);

    // Ack while idle is ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    check("idle_ack_req", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("idle_ack_rdata", ReadDataM, 32'hDEADBEEF);
    check("idle_ack_rvec", ReadVecDataM, 128'h0);

    // Vector write, ack every cycle: DoneM on cycle 6
    vec_access("vw", 1'b1, 32'h00000040, 128'h33333333_22222222_11111111_00000000, 0, 32'h0,
               128'h0000004C_00000048_00000044_00000040,
               128'h33333333_22222222_11111111_00000000);
    check("vw_stalls", stalls, 5);
    check("vw_rvec_hold", ReadVecDataM, 128'h0);

    // Vector read, ack after 2 wait cycles per beat
    vec_access("vr", 1'b0, 32'h00000200, 128'h0, 2, 32'hA0000000,
               128'h0000020C_00000208_00000204_00000200, 128'h0);
    check("vr_stalls", stalls, 13);
    check("vr_rvec", ReadVecDataM, 128'hA0000003_A0000002_A0000001_A0000000);
    check("vr_rdata_hold", ReadDataM, 32'hDEADBEEF);

    // Both write and read set: treated as a write
    @(posedge clk); #1;
    MemWriteM = 1'b1; MemReadM = 1'b1; VecM = 1'b0;
    ALUResultM = 32'h00000010; WriteDataM = 32'h12345678;
    @(negedge clk);
    check("both_c1_stall", StallM, 1'b1);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("both_we", mem_we, 1'b1);
    check("both_addr", mem_addr, 32'h00000010);
    check("both_wdata", mem_wdata, 32'h12345678);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; MemWriteM = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    check("both_done", DoneM, 1'b1);
    check("both_rdata_hold", ReadDataM, 32'hDEADBEEF);
    check("both_rvec_hold", ReadVecDataM, 128'hA0000003_A0000002_A0000001_A0000000);

    // Address wrap-around across 0
    vec_access("wrap", 1'b1, 32'hFFFFFFFB, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1, 32'h0,
               128'h00000004_00000000_FFFFFFFC_FFFFFFF8,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

    // Reset during beat 2 of a vector read
    @(posedge clk); #1;
    MemReadM = 1'b1; VecM = 1'b1; ALUResultM = 32'h00000300;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h00000011;
    @(posedge clk); #1;
    mem_rdata = 32'h00000022;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("rm_b2_addr", mem_addr, 32'h00000308);
    #1 rst = 1'b0;
    #1;
    check("rm_req", mem_req, 1'b0);
    check("rm_stall", StallM, 1'b0);
    check("rm_rvec", ReadVecDataM, 128'h0);
    check("rm_rdata", ReadDataM, 32'h0);
    MemReadM = 1'b0; VecM = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    vec_access("post", 1'b0, 32'h00000300, 128'h0, 0, 32'h000000C0,
               128'h0000030C_00000308_00000304_00000300, 128'h0);
    check("post_rvec", ReadVecDataM, 128'h000000C3_000000C2_000000C1_000000C0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
